// File: rtl/otter_l1_cache.sv
// Direct-mapped L1 cache, write-allocate, write-back (dirty bit) or write-through, between an OTTER port and burst memory.
// Hit: CPU_VALID one cycle after the request is sampled; a miss holds the CPU until its bursts finish, whatever the memory stalls.
module otter_l1_cache #(
   parameter int LINES          = 16,
   parameter int WORDS_PER_LINE = 4,
   parameter bit WRITE_BACK     = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CPU_RE,
   input  logic        CPU_WE,
   input  logic [31:0] CPU_ADDR,
   input  logic [31:0] CPU_DIN,
   input  logic [3:0]  CPU_BE,
   output logic [31:0] CPU_DOUT,
   output logic        CPU_VALID,
   output logic        MEM_RE,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_DIN,
   input  logic [31:0] MEM_DOUT,
   input  logic        MEM_VALID,
   output logic [31:0] HIT_CNT,
   output logic [31:0] MISS_CNT
);
   localparam int OFF    = $clog2(WORDS_PER_LINE) + 2;
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 32 - OFF - IDX_W;
   localparam int BEAT_W = $clog2(WORDS_PER_LINE);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HIT  = 3'd1;
   localparam logic [2:0] S_WB   = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_FILL = 3'd4;
   localparam logic [2:0] S_WT   = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic [3:0]        be_q, be_d;
   logic              we_q, we_d;
   logic              filled_q, filled_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;
   logic [31:0]       hit_cnt_q, hit_cnt_d;
   logic [31:0]       miss_cnt_q, miss_cnt_d;

   logic [TAG_W-1:0]                 tag_q  [LINES];
   logic [WORDS_PER_LINE-1:0][31:0]  data_q [LINES];

   logic              tag_we;
   logic              data_we;
   logic [BEAT_W-1:0] data_word;
   logic [31:0]       data_wdat;

   logic [TAG_W-1:0]  cpu_tag, req_tag;
   logic [IDX_W-1:0]  cpu_idx, req_idx;
   logic [BEAT_W-1:0] req_word;
   logic              unused_addr_lsb;

   assign cpu_tag         = CPU_ADDR[31 -: TAG_W];
   assign cpu_idx         = CPU_ADDR[OFF +: IDX_W];
   assign req_tag         = addr_q[31 -: TAG_W];
   assign req_idx         = addr_q[OFF +: IDX_W];
   assign req_word        = addr_q[2 +: BEAT_W];
   assign unused_addr_lsb = ^addr_q[1:0];

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      return res;
   endfunction

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      addr_d     = addr_q;
      din_d      = din_q;
      be_d       = be_q;
      we_d       = we_q;
      filled_d   = filled_q;
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      tag_we     = 1'b0;
      data_we    = 1'b0;
      data_word  = beat_q;
      data_wdat  = MEM_DOUT;
      case (state_q)
         S_IDLE: begin
            if (CPU_RE || CPU_WE) begin
               addr_d = CPU_ADDR;
               din_d  = CPU_DIN;
               be_d   = CPU_BE;
               we_d   = CPU_WE;
               beat_d = '0;
               if (valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag)) begin
                  filled_d = 1'b0;
                  state_d  = S_HIT;
               end else begin
                  filled_d   = 1'b1;
                  miss_cnt_d = sat_inc(miss_cnt_q);
                  state_d    = (WRITE_BACK && valid_q[cpu_idx] && dirty_q[cpu_idx]) ? S_WB : S_FILL;
               end
            end
         end
         S_HIT: begin
            if (we_q) begin
               data_we   = 1'b1;
               data_word = req_word;
               data_wdat = merge(data_q[req_idx][req_word], din_q, be_q);
               if (WRITE_BACK) dirty_d[req_idx] = 1'b1;
            end
            // an access completed by a fill was already counted as a miss
            if (!filled_q) hit_cnt_d = sat_inc(hit_cnt_q);
            state_d = (WRITE_BACK || !we_q) ? S_IDLE : S_WT;
         end
         S_WB, S_WT: begin
            if (MEM_VALID) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d = '0;
                  if (state_q == S_WB) begin
                     dirty_d[req_idx] = 1'b0;
                     state_d          = S_GAP;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_GAP: state_d = S_FILL;
         S_FILL: begin
            if (MEM_VALID) begin
               data_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  beat_d           = '0;
                  tag_we           = 1'b1;
                  valid_d[req_idx] = 1'b1;
                  dirty_d[req_idx] = 1'b0;
                  state_d          = S_HIT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         beat_q     <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         filled_q   <= 1'b0;
         valid_q    <= '0;
         dirty_q    <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         be_q       <= be_d;
         we_q       <= we_d;
         filled_q   <= filled_d;
         valid_q    <= valid_d;
         dirty_q    <= dirty_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // storage arrays carry no reset; validity lives in valid_q
   always_ff @(posedge CLK) begin
      if (!RST && tag_we)  tag_q[req_idx]             <= req_tag;
      if (!RST && data_we) data_q[req_idx][data_word] <= data_wdat;
   end

   always_comb begin
      CPU_VALID = (state_q == S_HIT);
      CPU_DOUT  = (state_q == S_HIT && !we_q) ? data_q[req_idx][req_word] : 32'd0;
      MEM_RE    = (state_q == S_FILL);
      MEM_WE    = (state_q == S_WB) || (state_q == S_WT);
      MEM_ADDR  = 32'd0;
      MEM_DIN   = 32'd0;
      if (MEM_RE) MEM_ADDR = {req_tag, req_idx, {OFF{1'b0}}};
      if (MEM_WE) begin
         MEM_ADDR = {tag_q[req_idx], req_idx, {OFF{1'b0}}};
         MEM_DIN  = data_q[req_idx][beat_q];
      end
   end

   assign HIT_CNT  = hit_cnt_q;
   assign MISS_CNT = miss_cnt_q;

endmodule

// File: tb/tb_otter_l1_cache.sv
// Bench for otter_l1_cache: a write-back and a write-through instance share one burst memory model.
// Expected CPU responses and memory beats are queued at issue time and checked by independent monitors.
module tb_otter_l1_cache;
   localparam int MEM_DELAY = 10;

   typedef struct { logic [31:0] dout; bit chk; int lat; int issue; } cpu_exp_t;
   typedef struct { bit we; logic [31:0] addr; logic [31:0] dat; int gap; } beat_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   sel = 1'b0;
   logic cpu_re = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_din = '0;
   logic [3:0]  cpu_be = '0;
   logic        mem_vld = 1'b0;
   logic [31:0] mem_dout = '0;

   logic [1:0]  d_re, d_we, d_valid, m_re, m_we, m_valid;
   logic [31:0] d_dout [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_din  [2];
   logic [31:0] hit_cnt [2];
   logic [31:0] miss_cnt [2];

   logic        s_valid, s_mre, s_mwe;
   logic [31:0] s_dout, s_maddr, s_mdin, s_hit, s_miss;

   int checks = 0, errors = 0, cyc = 0;
   int stall_cyc = 0, mbeat = 0, wcnt = 0, idle_cnt = 0;
   bit busy = 1'b0;
   cpu_exp_t  cpu_q [$];
   beat_exp_t beat_q [$];
   logic [31:0] wmem [logic [31:0]];
   cpu_exp_t  mon_e;
   beat_exp_t mdl_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign d_re    = sel ? {cpu_re, 1'b0}  : {1'b0, cpu_re};
   assign d_we    = sel ? {cpu_we, 1'b0}  : {1'b0, cpu_we};
   assign m_valid = sel ? {mem_vld, 1'b0} : {1'b0, mem_vld};
   assign s_valid = d_valid[sel];
   assign s_dout  = d_dout[sel];
   assign s_mre   = m_re[sel];
   assign s_mwe   = m_we[sel];
   assign s_maddr = m_addr[sel];
   assign s_mdin  = m_din[sel];
   assign s_hit   = hit_cnt[sel];
   assign s_miss  = miss_cnt[sel];

   otter_l1_cache #(.LINES(16), .WORDS_PER_LINE(4), .WRITE_BACK(1'b1)) u_wb (
      .CLK(clk), .RST(rst), .CPU_RE(d_re[0]), .CPU_WE(d_we[0]), .CPU_ADDR(cpu_addr),
      .CPU_DIN(cpu_din), .CPU_BE(cpu_be), .CPU_DOUT(d_dout[0]), .CPU_VALID(d_valid[0]),
      .MEM_RE(m_re[0]), .MEM_WE(m_we[0]), .MEM_ADDR(m_addr[0]), .MEM_DIN(m_din[0]),
      .MEM_DOUT(mem_dout), .MEM_VALID(m_valid[0]), .HIT_CNT(hit_cnt[0]), .MISS_CNT(miss_cnt[0]));

   otter_l1_cache #(.LINES(16), .WORDS_PER_LINE(4), .WRITE_BACK(1'b0)) u_wt (
      .CLK(clk), .RST(rst), .CPU_RE(d_re[1]), .CPU_WE(d_we[1]), .CPU_ADDR(cpu_addr),
      .CPU_DIN(cpu_din), .CPU_BE(cpu_be), .CPU_DOUT(d_dout[1]), .CPU_VALID(d_valid[1]),
      .MEM_RE(m_re[1]), .MEM_WE(m_we[1]), .MEM_ADDR(m_addr[1]), .MEM_DIN(m_din[1]),
      .MEM_DOUT(mem_dout), .MEM_VALID(m_valid[1]), .HIT_CNT(hit_cnt[1]), .MISS_CNT(miss_cnt[1]));

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] rd(input logic [31:0] a);
      return wmem.exists(a) ? wmem[a] : memval(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // CPU-side monitor
   always @(negedge clk) begin
      if (!rst && s_valid) begin
         if (cpu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL cpu_valid_unexpected: got CPU_VALID=1 expected 0");
         end else begin
            mon_e = cpu_q.pop_front();
            if (mon_e.chk) check("cpu_dout", s_dout, mon_e.dout);
            if (mon_e.lat >= 0) check("cpu_latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
         end
      end
   end

   // Burst memory model: MEM_DELAY cycles to first beat, stall_cyc idle cycles between beats
   always @(negedge clk) begin
      if (rst || !(s_mre || s_mwe)) begin
         busy = 1'b0; mem_vld = 1'b0; idle_cnt++;
      end else begin
         if (!busy) begin
            busy = 1'b1; mbeat = 0; wcnt = MEM_DELAY; mem_vld = 1'b0;
            if (beat_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL mem_burst_unexpected: got RE=%0b WE=%0b at %h expected no burst", s_mre, s_mwe, s_maddr);
            end else if (beat_q[0].gap >= 0) begin
               check("mem_gap_cycles", 32'(idle_cnt), 32'(beat_q[0].gap));
            end
            idle_cnt = 0;
         end else if (mem_vld) begin
            mem_vld = 1'b0; mbeat++; wcnt = stall_cyc;
         end
         if (mbeat < 4) begin
            if (beat_q.size() > 0) begin
               check("mem_we_held", {31'd0, s_mwe}, {31'd0, beat_q[0].we});
               check("mem_re_held", {31'd0, s_mre}, {31'd0, !beat_q[0].we});
               check("mem_addr", s_maddr, beat_q[0].addr);
            end
            if (wcnt == 0) begin
               mem_vld  = 1'b1;
               mem_dout = rd(s_maddr + 32'(mbeat * 4));
               if (beat_q.size() > 0) begin
                  mdl_e = beat_q.pop_front();
                  if (mdl_e.we) check("mem_wr_data", s_mdin, mdl_e.dat);
                  if (s_mwe) wmem[s_maddr + 32'(mbeat * 4)] = s_mdin;
               end
            end else begin
               wcnt--;
            end
         end
      end
   end

   task automatic push_burst(input bit we, input logic [31:0] base, input int gap,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      beat_exp_t b;
      logic [31:0] w [4];
      w = '{w0, w1, w2, w3};
      for (int i = 0; i < 4; i++) begin
         b = '{we: we, addr: base, dat: w[i], gap: (i == 0) ? gap : -1};
         beat_q.push_back(b);
      end
   endtask

   task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [31:0] exp_dout,
                         input bit do_chk, input int exp_lat);
      cpu_exp_t e;
      @(negedge clk);
      e = '{dout: exp_dout, chk: do_chk, lat: exp_lat, issue: cyc};
      cpu_q.push_back(e);
      cpu_addr = a; cpu_din = d; cpu_be = be; cpu_re = !is_wr; cpu_we = is_wr;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (s_valid) begin
            cpu_re = 1'b0; cpu_we = 1'b0;
            return;
         end
      end
      cpu_re = 1'b0; cpu_we = 1'b0;
      checks++; errors++;
      $display("FAIL cpu_timeout: got no CPU_VALID for %h expected one within 600 cycles", a);
   endtask

   task automatic drain();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         if (beat_q.size() == 0 && !busy) begin
            repeat (2) @(negedge clk);
            return;
         end
      end
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", beat_q.size());
   endtask

   task automatic cnt_check(input logic [31:0] hits, input logic [31:0] misses);
      @(negedge clk);
      check("hit_cnt", s_hit, hits);
      check("miss_cnt", s_miss, misses);
   endtask

   initial begin
      bit found;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_cpu_valid", {31'd0, d_valid[i]}, 32'd0);
         check("rst_mem_re", {31'd0, m_re[i]}, 32'd0);
         check("rst_mem_we", {31'd0, m_we[i]}, 32'd0);
         check("rst_cpu_dout", d_dout[i], 32'd0);
         check("rst_mem_addr", m_addr[i], 32'd0);
         check("rst_mem_din", m_din[i], 32'd0);
         check("rst_hit_cnt", hit_cnt[i], 32'd0);
         check("rst_miss_cnt", miss_cnt[i], 32'd0);
      end
      rst = 1'b0;

      // write-back instance: cold miss, hit, store hit, dirty eviction
      push_burst(1'b0, 32'h100, -1, '0, '0, '0, '0);
      access(1'b0, 32'h104, '0, 4'h0, 32'hFEFB_0104, 1'b1, -1);
      cnt_check(0, 1);
      access(1'b0, 32'h108, '0, 4'h0, 32'hFEF7_0108, 1'b1, 1);
      cnt_check(1, 1);
      access(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, '0, 1'b0, 1);
      cnt_check(2, 1);
      push_burst(1'b1, 32'h100, -1, 32'hFEFF_0100, 32'hFEFB_BEEF, 32'hFEF7_0108, 32'hFEF3_010C);
      push_burst(1'b0, 32'h1100, 1, '0, '0, '0, '0);
      access(1'b0, 32'h1104, '0, 4'h0, 32'hEEFB_1104, 1'b1, -1);
      cnt_check(2, 2);

      // zero byte-enable store still dirties the line
      access(1'b1, 32'h1108, 32'hFFFF_FFFF, 4'b0000, '0, 1'b0, 1);
      cnt_check(3, 2);
      push_burst(1'b1, 32'h1100, -1, 32'hEEFF_1100, 32'hEEFB_1104, 32'hEEF7_1108, 32'hEEF3_110C);
      push_burst(1'b0, 32'h2100, 1, '0, '0, '0, '0);
      access(1'b0, 32'h2104, '0, 4'h0, 32'hDEFB_2104, 1'b1, -1);
      cnt_check(3, 3);

      // stalled fill
      stall_cyc = 7;
      push_burst(1'b0, 32'h400, -1, '0, '0, '0, '0);
      access(1'b0, 32'h40C, '0, 4'h0, 32'hFBF3_040C, 1'b1, -1);
      stall_cyc = 0;
      access(1'b0, 32'h400, '0, 4'h0, 32'hFBFF_0400, 1'b1, 1);
      cnt_check(4, 4);

      // reset on the second fill beat
      beat_q.push_back('{we: 1'b0, addr: 32'h300, dat: '0, gap: -1});
      beat_q.push_back('{we: 1'b0, addr: 32'h300, dat: '0, gap: -1});
      @(negedge clk);
      cpu_addr = 32'h300; cpu_re = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (mem_vld && mbeat == 1) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_beat_seen", {31'd0, found}, 32'd1);
      rst = 1'b1; cpu_re = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_mem_re", {31'd0, s_mre}, 32'd0);
      check("rst_mid_cpu_valid", {31'd0, s_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cnt_check(0, 0);
      push_burst(1'b0, 32'h300, -1, '0, '0, '0, '0);
      access(1'b0, 32'h300, '0, 4'h0, 32'hFCFF_0300, 1'b1, -1);
      cnt_check(0, 1);

      // write-through instance
      @(negedge clk);
      sel = 1'b1;
      push_burst(1'b0, 32'h200, -1, '0, '0, '0, '0);
      push_burst(1'b1, 32'h200, 1, 32'h1234_5678, 32'hFDFB_0204, 32'hFDF7_0208, 32'hFDF3_020C);
      access(1'b1, 32'h200, 32'h1234_5678, 4'hF, '0, 1'b0, -1);
      drain();
      cnt_check(0, 1);
      access(1'b0, 32'h204, '0, 4'h0, 32'hFDFB_0204, 1'b1, 1);
      cnt_check(1, 1);
      push_burst(1'b1, 32'h200, -1, 32'h1234_5678, 32'hFDFB_0204, 32'hAABB_0208, 32'hFDF3_020C);
      access(1'b1, 32'h208, 32'hAABB_CCDD, 4'b1100, '0, 1'b0, 1);
      drain();
      cnt_check(2, 1);
      push_burst(1'b0, 32'h1200, -1, '0, '0, '0, '0);
      access(1'b0, 32'h1200, '0, 4'h0, 32'hEDFF_1200, 1'b1, -1);
      cnt_check(2, 2);

      drain();
      check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
      check("beat_q_empty", 32'(beat_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within 500000 time units");
      $fatal(1);
   end

endmodule
